// File: rtl/axi_rab_err_slave.sv
// AXI error slave: terminates translation-miss transactions with ERR_RESP.
// Independent write and read FSMs, one outstanding transaction each.
module axi_rab_err_slave #(
   parameter int unsigned AXI_ID_WIDTH   = 4,
   parameter int unsigned AXI_DATA_WIDTH = 64,
   parameter logic [1:0]  ERR_RESP       = 2'b10
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      aw_valid,
   output logic                      aw_ready,
   input  logic [AXI_ID_WIDTH-1:0]   aw_id,
   input  logic                      w_valid,
   output logic                      w_ready,
   input  logic                      w_last,
   output logic                      b_valid,
   input  logic                      b_ready,
   output logic [AXI_ID_WIDTH-1:0]   b_id,
   output logic [1:0]                b_resp,
   input  logic                      ar_valid,
   output logic                      ar_ready,
   input  logic [AXI_ID_WIDTH-1:0]   ar_id,
   input  logic [7:0]                ar_len,
   output logic                      r_valid,
   input  logic                      r_ready,
   output logic [AXI_ID_WIDTH-1:0]   r_id,
   output logic [AXI_DATA_WIDTH-1:0] r_data,
   output logic [1:0]                r_resp,
   output logic                      r_last
);

   typedef enum logic [1:0] {
      W_IDLE,
      W_DRAIN,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_e;

   w_state_e                w_state_q, w_state_d;
   logic [AXI_ID_WIDTH-1:0] b_id_q, b_id_d;

   r_state_e                r_state_q, r_state_d;
   logic [AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
   logic [7:0]              r_len_q, r_len_d;
   logic [7:0]              r_cnt_q, r_cnt_d;
   logic                    r_last_int;

   // Write path
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q <= W_IDLE;
         b_id_q    <= '0;
      end else begin
         w_state_q <= w_state_d;
         b_id_q    <= b_id_d;
      end
   end

   always_comb begin
      w_state_d = w_state_q;
      b_id_d    = b_id_q;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            aw_ready = 1'b1;
            if (aw_valid) begin
               b_id_d    = aw_id;
               w_state_d = W_DRAIN;
            end
         end
         W_DRAIN: begin
            w_ready = 1'b1;
            if (w_valid && w_last) begin
               w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            b_valid = 1'b1;
            if (b_ready) begin
               w_state_d = W_IDLE;
            end
         end
         default: begin
            w_state_d = W_IDLE;
         end
      endcase
   end

   assign b_id   = b_id_q;
   assign b_resp = ERR_RESP;

   // Read path
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
      end else begin
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
      end
   end

   // Counter stops at len, so a 256-beat burst never wraps before r_last
   assign r_last_int = (r_state_q == R_RESP) && (r_cnt_q == r_len_q);

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      ar_ready  = 1'b0;
      r_valid   = 1'b0;
      unique case (r_state_q)
         R_IDLE: begin
            ar_ready = 1'b1;
            if (ar_valid) begin
               r_id_d    = ar_id;
               r_len_d   = ar_len;
               r_cnt_d   = 8'd0;
               r_state_d = R_RESP;
            end
         end
         R_RESP: begin
            r_valid = 1'b1;
            if (r_ready) begin
               if (r_last_int) begin
                  r_state_d = R_IDLE;
               end else begin
                  r_cnt_d = r_cnt_q + 8'd1;
               end
            end
         end
         default: begin
            r_state_d = R_IDLE;
         end
      endcase
   end

   assign r_id   = r_id_q;
   assign r_data = '0;
   assign r_resp = ERR_RESP;
   assign r_last = r_last_int;

endmodule

// File: tb/tb_axi_rab_err_slave.sv
// Randomized + directed bench for axi_rab_err_slave.
// Reference model tracks transactions as pending-write and beats-remaining.
module tb_axi_rab_err_slave;
   localparam int IW = 4;
   localparam int DW = 64;
   localparam logic [1:0] ERR = 2'b10;

   logic          clk = 1'b0;
   logic          rstn;
   logic          aw_valid, aw_ready;
   logic [IW-1:0] aw_id;
   logic          w_valid, w_ready, w_last;
   logic          b_valid, b_ready;
   logic [IW-1:0] b_id;
   logic [1:0]    b_resp;
   logic          ar_valid, ar_ready;
   logic [IW-1:0] ar_id;
   logic [7:0]    ar_len;
   logic          r_valid, r_ready;
   logic [IW-1:0] r_id;
   logic [DW-1:0] r_data;
   logic [1:0]    r_resp;
   logic          r_last;

   always #5 clk = ~clk;

   axi_rab_err_slave #(
      .AXI_ID_WIDTH  (IW),
      .AXI_DATA_WIDTH(DW),
      .ERR_RESP      (ERR)
   ) dut (
      .clk     (clk),
      .rstn    (rstn),
      .aw_valid(aw_valid),
      .aw_ready(aw_ready),
      .aw_id   (aw_id),
      .w_valid (w_valid),
      .w_ready (w_ready),
      .w_last  (w_last),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_id    (b_id),
      .b_resp  (b_resp),
      .ar_valid(ar_valid),
      .ar_ready(ar_ready),
      .ar_id   (ar_id),
      .ar_len  (ar_len),
      .r_valid (r_valid),
      .r_ready (r_ready),
      .r_id    (r_id),
      .r_data  (r_data),
      .r_resp  (r_resp),
      .r_last  (r_last)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: a write is "pending" from AW until B; "wdone" once WLAST taken.
   // A read is just a number of beats still owed.
   bit            m_have_aw = 0;
   bit            m_wdone   = 0;
   logic [IW-1:0] m_aw_id   = '0;
   int            m_rrem    = 0;
   logic [IW-1:0] m_rid     = '0;
   int            nb = 0, nr = 0, nw = 0, nlast = 0;

   task automatic expect_eq(input string tag,
                            input logic [63:0] got,
                            input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   task automatic check_outs();
      expect_eq("aw_ready", 64'(aw_ready), 64'(!m_have_aw));
      expect_eq("w_ready", 64'(w_ready), 64'(m_have_aw && !m_wdone));
      expect_eq("b_valid", 64'(b_valid), 64'(m_wdone));
      if (m_wdone) expect_eq("b_id", 64'(b_id), 64'(m_aw_id));
      expect_eq("b_resp", 64'(b_resp), 64'(ERR));
      expect_eq("ar_ready", 64'(ar_ready), 64'(m_rrem == 0));
      expect_eq("r_valid", 64'(r_valid), 64'(m_rrem > 0));
      expect_eq("r_last", 64'(r_last), 64'(m_rrem == 1));
      if (m_rrem > 0) expect_eq("r_id", 64'(r_id), 64'(m_rid));
      expect_eq("r_data", 64'(r_data), 64'd0);
      expect_eq("r_resp", 64'(r_resp), 64'(ERR));
   endtask

   task automatic model_reset();
      m_have_aw = 0;
      m_wdone   = 0;
      m_aw_id   = '0;
      m_rrem    = 0;
      m_rid     = '0;
   endtask

   task automatic cycle();
      bit            aw_hs, w_hs, wl_hs, b_hs, ar_hs, r_hs, rl;
      logic [IW-1:0] awi, ari;
      int            len;
      aw_hs = !m_have_aw && aw_valid;
      w_hs  = m_have_aw && !m_wdone && w_valid;
      wl_hs = w_hs && w_last;
      b_hs  = m_wdone && b_ready;
      ar_hs = (m_rrem == 0) && ar_valid;
      r_hs  = (m_rrem > 0) && r_ready;
      rl    = (m_rrem == 1);
      awi   = aw_id;
      ari   = ar_id;
      len   = int'(ar_len);
      @(posedge clk);
      #1;
      if (rstn) begin
         if (aw_hs) begin
            m_have_aw = 1;
            m_aw_id   = awi;
         end
         if (w_hs) nw++;
         if (wl_hs) m_wdone = 1;
         if (b_hs) begin
            m_have_aw = 0;
            m_wdone   = 0;
            nb++;
         end
         if (ar_hs) begin
            m_rrem = len + 1;
            m_rid  = ari;
         end
         if (r_hs) begin
            m_rrem--;
            nr++;
            if (rl) nlast++;
         end
      end
      check_outs();
   endtask

   task automatic idle_inputs();
      aw_valid = 0; aw_id = '0;
      w_valid  = 0; w_last = 0;
      b_ready  = 0;
      ar_valid = 0; ar_id = '0; ar_len = '0;
      r_ready  = 0;
   endtask

   task automatic async_reset();
      #2;
      rstn = 0;
      #1;
      model_reset();
      expect_eq("rst_r_valid", 64'(r_valid), 64'd0);
      expect_eq("rst_ar_ready", 64'(ar_ready), 64'd1);
      expect_eq("rst_aw_ready", 64'(aw_ready), 64'd1);
      expect_eq("rst_w_ready", 64'(w_ready), 64'd0);
      expect_eq("rst_b_valid", 64'(b_valid), 64'd0);
      expect_eq("rst_r_last", 64'(r_last), 64'd0);
      expect_eq("rst_b_id", 64'(b_id), 64'd0);
      expect_eq("rst_r_id", 64'(r_id), 64'd0);
      check_outs();
      cycle();
      rstn = 1;
   endtask

   initial begin
      int g, nb0, nr0, nw0, nl0;
      rstn = 0;
      idle_inputs();
      #2;
      expect_eq("rst_b_id", 64'(b_id), 64'd0);
      expect_eq("rst_r_id", 64'(r_id), 64'd0);
      check_outs();
      @(posedge clk);
      #1;
      rstn = 1;
      cycle();

      // AW id=3, four W beats, B one cycle after WLAST
      nb0 = nb;
      aw_valid = 1; aw_id = 4'd3;
      cycle();
      aw_valid = 0;
      w_valid = 1;
      for (int i = 0; i < 4; i++) begin
         w_last = (i == 3);
         cycle();
      end
      w_valid = 0; w_last = 0;
      expect_eq("b_lat", 64'(b_valid), 64'd1);
      expect_eq("b_id3", 64'(b_id), 64'd3);
      b_ready = 1;
      cycle();
      cycle();
      b_ready = 0;
      expect_eq("b_count", 64'(nb - nb0), 64'd1);

      // W beats before AW are stalled
      nb0 = nb; nw0 = nw; g = 0;
      while ((nw - nw0) < 4 && g < 30) begin
         w_valid  = 1;
         w_last   = ((nw - nw0) == 3);
         aw_valid = (g == 3);
         aw_id    = 4'd7;
         cycle();
         g++;
      end
      expect_eq("w_drain_tmo", 64'(g < 30), 64'd1);
      idle_inputs();
      b_ready = 1;
      g = 0;
      while (nb == nb0 && g < 10) begin cycle(); g++; end
      b_ready = 0;
      expect_eq("w_beats", 64'(nw - nw0), 64'd4);
      expect_eq("w_b_count", 64'(nb - nb0), 64'd1);

      // AR id=5 len=0
      nr0 = nr; nl0 = nlast;
      ar_valid = 1; ar_id = 4'd5; ar_len = 8'd0;
      cycle();
      ar_valid = 0;
      expect_eq("r0_last", 64'(r_last), 64'd1);
      expect_eq("r0_id", 64'(r_id), 64'd5);
      r_ready = 1;
      cycle();
      r_ready = 0;
      expect_eq("r0_beats", 64'(nr - nr0), 64'd1);

      // len=255 with toggling r_ready
      nr0 = nr; nl0 = nlast;
      ar_valid = 1; ar_id = 4'd9; ar_len = 8'd255;
      cycle();
      ar_valid = 0;
      g = 0;
      while (m_rrem > 0 && g < 700) begin
         r_ready = g[0];
         cycle();
         g++;
      end
      r_ready = 0;
      expect_eq("r255_tmo", 64'(g < 700), 64'd1);
      expect_eq("r255_beats", 64'(nr - nr0), 64'd256);
      expect_eq("r255_lasts", 64'(nlast - nl0), 64'd1);

      // Concurrent write and read, B held off
      nr0 = nr;
      aw_valid = 1; aw_id = 4'hA;
      ar_valid = 1; ar_id = 4'd6; ar_len = 8'd3;
      cycle();
      aw_valid = 0; ar_valid = 0;
      w_valid = 1; w_last = 1;
      r_ready = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         w_valid = 0; w_last = 0;
      end
      r_ready = 0;
      expect_eq("cc_r_beats", 64'(nr - nr0), 64'd4);
      expect_eq("cc_b_hold", 64'(b_valid), 64'd1);
      expect_eq("cc_b_id", 64'(b_id), 64'hA);
      b_ready = 1;
      cycle();
      b_ready = 0;

      // Reset during beat 2 of 8
      ar_valid = 1; ar_id = 4'd2; ar_len = 8'd7;
      cycle();
      ar_valid = 0;
      r_ready = 1;
      cycle();
      r_ready = 0;
      async_reset();
      nr0 = nr;
      r_ready = 1;
      for (int i = 0; i < 5; i++) cycle();
      expect_eq("rst_no_beats", 64'(nr - nr0), 64'd0);
      idle_inputs();

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         aw_valid = ($urandom_range(0, 3) == 0);
         aw_id    = IW'($urandom);
         w_valid  = $urandom_range(0, 1) != 0;
         w_last   = ($urandom_range(0, 3) == 0);
         b_ready  = $urandom_range(0, 1) != 0;
         ar_valid = ($urandom_range(0, 3) == 0);
         ar_id    = IW'($urandom);
         ar_len   = ($urandom_range(0, 15) == 0) ?
                    8'($urandom) : 8'($urandom_range(0, 7));
         r_ready  = $urandom_range(0, 2) != 0;
         if (i == 1500) async_reset();
         cycle();
      end
      idle_inputs();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axi_rab_err_slave.md
AXI_RAB_ERR_SLAVE -- requirements
Module: axi_rab_err_slave

Interface
REQ-001 Parameter AXI_ID_WIDTH, default 4: width of all ID fields.
REQ-002 Parameter AXI_DATA_WIDTH, default 64: width of r_data.
REQ-003 Parameter ERR_RESP, default 2'b10 (SLVERR): response code returned on b_resp and r_resp.
REQ-004 Port clk, input, 1: single clock, all state on rising edge.
REQ-005 Port rstn, input, 1: reset, asynchronous and active-low.
REQ-006 Port aw_valid, input, 1; aw_ready, output, 1; aw_id, input, AXI_ID_WIDTH: write address channel.
REQ-007 Port w_valid, input, 1; w_ready, output, 1; w_last, input, 1: write data channel; data and strobe are not consumed.
REQ-008 Port b_valid, output, 1; b_ready, input, 1; b_id, output, AXI_ID_WIDTH; b_resp, output, 2: write response channel.
REQ-009 Port ar_valid, input, 1; ar_ready, output, 1; ar_id, input, AXI_ID_WIDTH; ar_len, input, 8: read address channel.
REQ-010 Port r_valid, output, 1; r_ready, input, 1; r_id, output, AXI_ID_WIDTH; r_data, output, AXI_DATA_WIDTH; r_resp, output, 2; r_last, output, 1: read data channel.

Function
REQ-011 The block SHALL terminate every AXI transaction routed to it (translation miss) with ERR_RESP; write and read paths SHALL be independent FSMs, one outstanding transaction each.
REQ-012 Write FSM states SHALL be W_IDLE, W_DRAIN, W_RESP.
REQ-013 In W_IDLE, aw_ready SHALL be 1; on aw_valid&aw_ready, aw_id SHALL be latched and the FSM SHALL move to W_DRAIN.
REQ-014 In W_DRAIN, w_ready SHALL be 1; each w_valid beat SHALL be discarded; on w_valid&w_last the FSM SHALL move to W_RESP.
REQ-015 In W_RESP, b_valid SHALL be 1 with b_id = latched ID and b_resp = ERR_RESP; on b_ready the FSM SHALL return to W_IDLE.
REQ-016 aw_ready SHALL be 0 outside W_IDLE, w_ready SHALL be 0 outside W_DRAIN, b_valid SHALL be 0 outside W_RESP; W beats arriving before AW acceptance SHALL be stalled, not dropped.
REQ-017 Read FSM states SHALL be R_IDLE, R_RESP.
REQ-018 In R_IDLE, ar_ready SHALL be 1; on ar_valid&ar_ready, ar_id and ar_len SHALL be latched, beat counter cleared to 0, FSM to R_RESP.
REQ-019 In R_RESP, r_valid SHALL be 1, r_id = latched ID, r_data = 0, r_resp = ERR_RESP, r_last = (counter == latched len).
REQ-020 On r_valid&r_ready with r_last=0 the 8-bit counter SHALL increment; with r_last=1 the FSM SHALL return to R_IDLE.
REQ-021 A read burst SHALL return exactly ar_len+1 beats (1 to 256); ar_len=255 SHALL not wrap the counter before r_last.
REQ-022 Outputs SHALL hold stable while valid is high and ready is low (AXI stability rule).
REQ-023 Minimum latency: AW-to-B-eligible after WLAST accepted is 1 cycle; AR accept to first r_valid is 1 cycle; back-to-back transactions SHALL incur exactly one IDLE cycle.
REQ-024 Simultaneous write and read activity SHALL not interact.

Reset
REQ-025 While rstn=0, both FSMs SHALL be in IDLE; aw_ready=1, ar_ready=1, w_ready=0, b_valid=0, r_valid=0, r_last=0; latched IDs, len, counter SHALL be 0; b_resp/r_resp SHALL read ERR_RESP.
REQ-026 Reset asserted mid-transaction SHALL abort it immediately; no partial response SHALL be issued after reset release.

Verification
REQ-027 AW id=3, then 4 W beats (last on 4th), b_ready=1 -> one b_valid pulse, b_id=3, b_resp=2'b10, 1 cycle after WLAST accepted.
REQ-028 W beats presented before AW -> w_ready=0 until AW accepted; all 4 beats then drained, single B.
REQ-029 AR id=5 len=0 -> one R beat, r_last=1, r_resp=2'b10, r_data=0, r_id=5.
REQ-030 AR len=255 with r_ready toggling 1/0 -> exactly 256 beats, r_last only on 256th, outputs stable during stalls.
REQ-031 Write and read issued same cycle, b_ready held 0 for 10 cycles -> read burst completes unaffected, b_valid held with constant b_id.
REQ-032 rstn pulled low during R_RESP beat 2 of 8 -> r_valid=0 asynchronously, ar_ready=1 after release, no further R beats.
